// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequences the UART receiver datapath.
// Generates the oversample tick, gates new frames via rx_enabled, captures each
// completed byte into a show-ahead FIFO and flags overrun / idle timeout.
// Ports:
//   clk, rstN               clock, synchronous active-low reset
//   cfg_en, cfg_div         host receive enable, tick period minus 1
//   rx_busy, rx_done, rx_data  receiver status and assembled byte
//   rx_enabled, s_tick      receiver frame permit, one-cycle oversample tick
//   rd_en, rd_data          FIFO pop and show-ahead head
//   fifo_empty/full/count   FIFO status
//   overrun, clr_overrun    sticky dropped-byte flag and its clear
//   rx_timeout              one-cycle inter-byte idle timeout pulse
module uart_rx_ctrl #(
   parameter int unsigned DIV_W         = 16,
   parameter int unsigned FIFO_DEPTH    = 8,
   parameter int unsigned TIMEOUT_TICKS = 640
) (
   input  logic                          clk,
   input  logic                          rstN,
   input  logic                          cfg_en,
   input  logic [DIV_W-1:0]              cfg_div,
   input  logic                          rx_busy,
   input  logic                          rx_done,
   input  logic [7:0]                    rx_data,
   output logic                          rx_enabled,
   output logic                          s_tick,
   input  logic                          rd_en,
   output logic [7:0]                    rd_data,
   output logic                          fifo_empty,
   output logic                          fifo_full,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overrun,
   input  logic                          clr_overrun,
   output logic                          rx_timeout
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned TO_W  = $clog2(TIMEOUT_TICKS + 1);

   typedef enum logic [2:0] {
      ST_OFF,
      ST_ARM,
      ST_RX,
      ST_HOLD,
      ST_STOP
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [DIV_W-1:0]   tick_cnt;
   logic               done_q;
   logic [7:0]         mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   rd_ptr_nxt;
   logic [CNT_W-1:0]   count_nxt;
   logic [TO_W-1:0]    to_cnt;
   logic               push;
   logic               pop;
   logic               wr;
   logic               full_nxt;
   logic               to_clr;
   logic               to_inc;
   logic [7:0]         head_nxt;

   // Next state; RX decides HOLD vs ARM on the occupancy after this cycle.
   function automatic state_t next_state(input state_t s, input logic en,
                                         input logic busy, input logic full,
                                         input logic full_after);
      next_state = s;
      case (s)
         ST_OFF:  if (en) next_state = ST_ARM;
         ST_ARM: begin
            if (!en)       next_state = ST_OFF;
            else if (busy) next_state = ST_RX;
            else if (full) next_state = ST_HOLD;
         end
         ST_RX: begin
            if (!en)        next_state = ST_STOP;
            else if (!busy) next_state = full_after ? ST_HOLD : ST_ARM;
         end
         ST_HOLD: begin
            if (!en)        next_state = ST_OFF;
            else if (!full) next_state = ST_ARM;
         end
         ST_STOP: begin
            if (!busy)    next_state = ST_OFF;
            else if (en)  next_state = ST_RX;
         end
         default: next_state = ST_OFF;
      endcase
   endfunction

   // Capture/FIFO control: a dropped byte still counts as a push for the timeout.
   assign push       = rx_done & ~done_q & (state != ST_OFF);
   assign pop        = rd_en & ~fifo_empty;
   assign wr         = push & (~fifo_full | pop);
   assign count_nxt  = fifo_count + CNT_W'(wr) - CNT_W'(pop);
   assign full_nxt   = (count_nxt == CNT_W'(FIFO_DEPTH));
   assign rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
   // Head bypasses the array when the incoming byte lands at the new head slot.
   assign head_nxt   = (wr && (wr_ptr == rd_ptr_nxt)) ? rx_data : mem[rd_ptr_nxt];
   assign to_clr     = push | pop | (state != ST_ARM) | fifo_empty;
   assign to_inc     = ~to_clr & s_tick & (to_cnt < TO_W'(TIMEOUT_TICKS));
   assign state_nxt  = next_state(state, cfg_en, rx_busy, fifo_full, full_nxt);

   // FSM and frame permit
   always_ff @(posedge clk) begin
      if (!rstN) begin
         state      <= ST_OFF;
         rx_enabled <= 1'b0;
      end else begin
         state      <= state_nxt;
         rx_enabled <= (state_nxt == ST_ARM) || (state_nxt == ST_RX);
      end
   end

   // Tick generator; >= makes a live divisor decrease wrap on the next cycle
   always_ff @(posedge clk) begin
      if (!rstN || state == ST_OFF) begin
         tick_cnt <= '0;
         s_tick   <= 1'b0;
      end else if (tick_cnt >= cfg_div) begin
         tick_cnt <= '0;
         s_tick   <= 1'b1;
      end else begin
         tick_cnt <= tick_cnt + DIV_W'(1);
         s_tick   <= 1'b0;
      end
   end

   // FIFO storage (not reset)
   always_ff @(posedge clk) begin
      if (rstN && wr) mem[wr_ptr] <= rx_data;
   end

   // FIFO pointers, status and overrun
   always_ff @(posedge clk) begin
      if (!rstN) begin
         done_q     <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         fifo_empty <= 1'b1;
         fifo_full  <= 1'b0;
         rd_data    <= '0;
         overrun    <= 1'b0;
      end else begin
         done_q     <= rx_done;
         if (wr) wr_ptr <= wr_ptr + PTR_W'(1);
         rd_ptr     <= rd_ptr_nxt;
         fifo_count <= count_nxt;
         fifo_empty <= (count_nxt == '0);
         fifo_full  <= full_nxt;
         if (wr || pop) rd_data <= head_nxt;
         if (push && fifo_full && !pop) overrun <= 1'b1;
         else if (clr_overrun)          overrun <= 1'b0;
      end
   end

   // Idle timeout: counts ticks while bytes wait in ARM, pulses once, then saturates
   always_ff @(posedge clk) begin
      if (!rstN) begin
         to_cnt     <= '0;
         rx_timeout <= 1'b0;
      end else begin
         if (to_clr)      to_cnt <= '0;
         else if (to_inc) to_cnt <= to_cnt + TO_W'(1);
         rx_timeout <= to_inc && (to_cnt == TO_W'(TIMEOUT_TICKS - 1));
      end
   end

endmodule
